// File: rtl/me_store_buf.sv
// Store buffer between the memory-access stage and data memory: in-order FIFO
// drained by a two-state bus FSM, with load RAW-hazard and full-store stall.
module me_store_buf #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_we_i,
  input  logic [31:0]                mem_waddr_i,
  input  logic [3:0]                 mem_w_sel_i,
  input  logic [31:0]                mem_data_i,
  input  logic                       ld_req_i,
  input  logic [31:0]                ld_addr_i,
  output logic                       bus_req_o,
  output logic [31:0]                bus_addr_o,
  output logic [3:0]                 bus_sel_o,
  output logic [31:0]                bus_data_o,
  input  logic                       bus_ack_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       hold_flag_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } sb_ent_t;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  sb_ent_t          r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  state_t           r_state, w_state_nxt;
  sb_ent_t          r_bus;

  logic             w_full, w_push_try, w_push, w_pop, w_load;
  logic [CW-1:0]    w_cnt_nxt;
  logic [PW-1:0]    w_rd_ptr_inc;
  sb_ent_t          w_new, w_load_ent;
  logic [DEPTH-1:0] w_hit;
  logic             w_unused;

  assign w_unused     = ^{ld_addr_i[1:0], mem_waddr_i[1:0]};
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_push_try   = mem_we_i && (mem_w_sel_i != 4'b0000);
  assign w_push       = w_push_try && !w_full;
  assign w_pop        = (r_state == S_REQ) && bus_ack_i;
  assign w_cnt_nxt    = r_count + CW'(w_push) - CW'(w_pop);
  assign w_rd_ptr_inc = r_rd_ptr + PW'(1);
  assign w_new        = '{addr: mem_waddr_i[31:2], sel: mem_w_sel_i, data: mem_data_i};

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_ent  = r_mem[r_rd_ptr];
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = S_REQ;
          w_load      = 1'b1;
        end
      end
      S_REQ: begin
        if (bus_ack_i) begin
          if (w_cnt_nxt != '0) begin
            w_load = 1'b1;
            // With one entry left the next head is the store arriving this edge
            w_load_ent = (r_count == CW'(1)) ? w_new : r_mem[w_rd_ptr_inc];
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_new;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= S_IDLE;
      r_bus    <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_rd_ptr        <= w_rd_ptr_inc;
        r_vld[r_rd_ptr] <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + PW'(1);
        r_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_load) r_bus <= w_load_ent;
    end
  end

  // The entry currently on the bus stays valid until its ack, so it is still checked
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign w_hit[i] = r_vld[i] && (r_mem[i].addr == ld_addr_i[31:2]);
  end

  assign hold_flag_o = (ld_req_i && (|w_hit)) || (w_push_try && w_full);
  assign bus_req_o   = (r_state == S_REQ);
  assign bus_addr_o  = {r_bus.addr, 2'b00};
  assign bus_sel_o   = r_bus.sel;
  assign bus_data_o  = r_bus.data;
  assign full_o      = w_full;
  assign empty_o     = (r_count == '0);
  assign count_o     = r_count;
endmodule

// File: tb/tb_me_store_buf.sv
// Directed bench for me_store_buf: single store, fill/full, backpressure,
// RAW hazard, simultaneous push/pop, wrap-around, reset mid-drain.
module tb_me_store_buf;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_we_i;
  logic [31:0] mem_waddr_i;
  logic [3:0]  mem_w_sel_i;
  logic [31:0] mem_data_i;
  logic        ld_req_i;
  logic [31:0] ld_addr_i;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_o;
  logic        bus_ack_i;
  logic        full_o, empty_o, hold_flag_o;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  me_store_buf #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_w_sel_i(mem_w_sel_i),
    .mem_data_i(mem_data_i), .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_data_o(bus_data_o), .bus_ack_i(bus_ack_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .hold_flag_o(hold_flag_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    mem_we_i = 1'b1; mem_waddr_i = a; mem_w_sel_i = s; mem_data_i = d;
  endtask

  task automatic nopush();
    mem_we_i = 1'b0; mem_w_sel_i = 4'h0;
  endtask

  initial begin
    int k, nd;
    rst_n = 1'b1; bus_ack_i = 1'b0; ld_req_i = 1'b0; ld_addr_i = '0;
    mem_we_i = 1'b0; mem_waddr_i = '0; mem_w_sel_i = '0; mem_data_i = '0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("rst_req",   32'(bus_req_o),   32'd0);
    check("rst_addr",  bus_addr_o,       32'd0);
    check("rst_sel",   32'(bus_sel_o),   32'd0);
    check("rst_data",  bus_data_o,       32'd0);
    check("rst_empty", 32'(empty_o),     32'd1);
    check("rst_full",  32'(full_o),      32'd0);
    check("rst_count", 32'(count_o),     32'd0);
    check("rst_hold",  32'(hold_flag_o), 32'd0);

    // sel=0 store is dropped
    push(32'h0000_0100, 4'h0, 32'h1234_5678);
    tick(); nopush();
    check("sel0_count", 32'(count_o), 32'd0);
    check("sel0_empty", 32'(empty_o), 32'd1);

    // single store, ack always high
    bus_ack_i = 1'b1;
    push(32'h0000_1006, 4'b1100, 32'hABCD_0000);
    tick(); nopush();
    check("s1_cnt1", 32'(count_o),   32'd1);
    check("s1_req0", 32'(bus_req_o), 32'd0);
    tick();
    check("s1_req1", 32'(bus_req_o), 32'd1);
    check("s1_addr", bus_addr_o,     32'h0000_1004);
    check("s1_sel",  32'(bus_sel_o), 32'hC);
    check("s1_data", bus_data_o,     32'hABCD_0000);
    tick();
    check("s1_req_off", 32'(bus_req_o), 32'd0);
    check("s1_cnt0",    32'(count_o),   32'd0);
    check("s1_empty",   32'(empty_o),   32'd1);

    // fill to DEPTH with ack low; fifth store rejected
    bus_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'h10 + 32'(i) * 4, 4'hF, 32'hD0 + 32'(i));
      tick();
    end
    check("fill_cnt",  32'(count_o), 32'd4);
    check("fill_full", 32'(full_o),  32'd1);
    push(32'h20, 4'hF, 32'hD4);
    #1;
    check("fill_hold", 32'(hold_flag_o), 32'd1);
    tick(); nopush();
    check("fill_rej_cnt", 32'(count_o), 32'd4);
    bus_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fill_drain_req",  32'(bus_req_o), 32'd1);
      check("fill_drain_addr", bus_addr_o, 32'h10 + 32'(i) * 4);
      check("fill_drain_data", bus_data_o, 32'hD0 + 32'(i));
      tick();
    end
    check("fill_end_req", 32'(bus_req_o), 32'd0);
    check("fill_end_cnt", 32'(count_o),   32'd0);
    bus_ack_i = 1'b0;

    // hazard and backpressure on a single entry
    push(32'h0000_2000, 4'h3, 32'h0000_0055);
    tick(); nopush();
    tick();
    check("bp_req", 32'(bus_req_o), 32'd1);
    ld_req_i = 1'b1; ld_addr_i = 32'h0000_2003;
    #1;
    check("haz_hit", 32'(hold_flag_o), 32'd1);
    ld_addr_i = 32'h0000_2004;
    #1;
    check("haz_miss", 32'(hold_flag_o), 32'd0);
    ld_addr_i = 32'h0000_2003;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_addr", bus_addr_o,     32'h0000_2000);
      check("bp_sel",  32'(bus_sel_o), 32'h3);
      check("bp_data", bus_data_o,     32'h0000_0055);
      check("bp_cnt",  32'(count_o),   32'd1);
    end
    check("haz_still", 32'(hold_flag_o), 32'd1);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    check("bp_pop_cnt", 32'(count_o),     32'd0);
    check("bp_pop_req", 32'(bus_req_o),   32'd0);
    check("haz_clear",  32'(hold_flag_o), 32'd0);
    ld_req_i = 1'b0;

    // simultaneous push/pop at count=2
    push(32'hA0, 4'hF, 32'h0); tick();
    push(32'hA4, 4'hF, 32'h1); tick();
    check("pp_cnt2",  32'(count_o), 32'd2);
    check("pp_addr0", bus_addr_o,   32'hA0);
    bus_ack_i = 1'b1;
    push(32'hA8, 4'hF, 32'h2); tick(); nopush();
    check("pp_cnt_same", 32'(count_o), 32'd2);
    check("pp_addr1",    bus_addr_o,   32'hA4);
    tick();
    check("pp_addr2", bus_addr_o,   32'hA8);
    check("pp_cnt1",  32'(count_o), 32'd1);
    tick();
    check("pp_idle", 32'(bus_req_o), 32'd0);
    check("pp_cnt0", 32'(count_o),   32'd0);

    // wrap-around: 10 stores, back-to-back then alternate cycles, ack held high
    k = 0; nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (k < 10 && (k < 5 || (c % 2) == 0)) begin
        push(32'h300 + 32'(k) * 4, 4'hF, 32'(k));
        k++;
      end else begin
        nopush();
      end
      tick();
      if (bus_req_o) begin
        check("wrap_order", bus_addr_o, 32'h300 + 32'(nd) * 4);
        check("wrap_data",  bus_data_o, 32'(nd));
        nd++;
      end
    end
    nopush();
    check("wrap_drained", 32'(nd), 32'd10);
    check("wrap_empty",   32'(empty_o), 32'd1);

    // full + pop same cycle rejects the push, then reset mid-REQ
    bus_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'h50 + 32'(i) * 4, 4'hF, 32'(i));
      tick();
    end
    bus_ack_i = 1'b1;
    push(32'h60, 4'hF, 32'h9);
    #1;
    check("fullpop_hold", 32'(hold_flag_o), 32'd1);
    tick(); nopush();
    bus_ack_i = 1'b0;
    check("fullpop_cnt",  32'(count_o), 32'd3);
    check("fullpop_addr", bus_addr_o,   32'h54);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("mrst_req",   32'(bus_req_o), 32'd0);
    check("mrst_empty", 32'(empty_o),   32'd1);
    check("mrst_addr",  bus_addr_o,     32'd0);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    check("mrst_ack_req", 32'(bus_req_o), 32'd0);
    check("mrst_ack_cnt", 32'(count_o),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
